dot_scan_driver: RTL and testbench

DOT_SCAN_DRIVER -- requirements
Module: dot_scan_driver

---
 rtl/dot_scan_driver.sv | 137 +++++++++++++
 tb/tb_dot_scan_driver.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dot_scan_driver.sv
// Row-scanning driver for an 8x8 dot matrix: one row lit per SCAN_DIV cycles.
// Define DOT_BLANK_EN to add BLANK_CYCLES dark cycles after every row.
module dot_scan_driver #(
    parameter int SCAN_DIV     = 2500,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] col_data,
    output logic [2:0] row_count,
    output logic [7:0] dot_row,
    output logic [7:0] dot_col,
    output logic       frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    if (SCAN_DIV < 1 || BLANK_CYCLES < 1) begin : g_param_check
        $error("dot_scan_driver: SCAN_DIV and BLANK_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHOW  = 2'd2
`ifdef DOT_BLANK_EN
        ,
        BLANK = 2'd3
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    drow_q, drow_d;
    logic [7:0]    dcol_q, dcol_d;

`ifdef DOT_BLANK_EN
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLK_LAST = BW'(BLANK_CYCLES - 1);

    logic [BW-1:0] blk_q, blk_d;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pre_d   = pre_q;
        drow_d  = 8'hFF;
        dcol_d  = 8'h00;
`ifdef DOT_BLANK_EN
        blk_d   = blk_q;
`endif
        case (state_q)
            IDLE: begin
                row_d = 3'd0;
                pre_d = '0;
                if (enable) state_d = LOAD;
            end
            LOAD: begin
                state_d = SHOW;
                pre_d   = '0;
                drow_d  = ~(8'b1 << row_q);
                dcol_d  = col_data;
            end
            SHOW: begin
                drow_d = drow_q;
                dcol_d = dcol_q;
                if (pre_q == PRE_LAST) begin
                    drow_d = 8'hFF;
                    dcol_d = 8'h00;
`ifdef DOT_BLANK_EN
                    state_d = BLANK;
                    blk_d   = '0;
`else
                    state_d = LOAD;
                    row_d   = row_q + 3'd1;
`endif
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
`ifdef DOT_BLANK_EN
            BLANK: begin
                if (blk_q == BLK_LAST) begin
                    state_d = LOAD;
                    row_d   = row_q + 3'd1;
                end else begin
                    blk_d = blk_q + BW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // Dropping enable abandons the frame; the next run restarts at row 0.
        if (!enable) begin
            state_d = IDLE;
            row_d   = 3'd0;
            pre_d   = '0;
            drow_d  = 8'hFF;
            dcol_d  = 8'h00;
`ifdef DOT_BLANK_EN
            blk_d   = '0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= 3'd0;
            pre_q   <= '0;
            drow_q  <= 8'hFF;
            dcol_q  <= 8'h00;
`ifdef DOT_BLANK_EN
            blk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pre_q   <= pre_d;
            drow_q  <= drow_d;
            dcol_q  <= dcol_d;
`ifdef DOT_BLANK_EN
            blk_q   <= blk_d;
`endif
        end
    end

    assign row_count  = row_q;
    assign dot_row    = drow_q;
    assign dot_col    = dcol_q;
    assign frame_done = (state_q == LOAD) && (row_q == 3'd0);

endmodule

// File: tb/tb_dot_scan_driver.sv
// Scoreboard bench for dot_scan_driver: a timeline model predicts every cycle,
// a negedge monitor pops and compares.
module tb_dot_scan_driver;

    localparam int SD = 4;
`ifdef DOT_BLANK_EN
    localparam int BC = 2;
`else
    localparam int BC = 0;
`endif
    localparam int P = 1 + SD + BC;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] col_data;
    logic [2:0] row_count;
    logic [7:0] dot_row;
    logic [7:0] dot_col;
    logic       frame_done;

    dot_scan_driver #(
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .col_data  (col_data),
        .row_count (row_count),
        .dot_row   (dot_row),
        .dot_col   (dot_col),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] r;
        logic [7:0] dr;
        logic [7:0] dc;
        logic       fd;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // t counts cycles since the first LOAD of the current run.
    function automatic obs_t model(bit run, int t, logic [7:0] col);
        obs_t o;
        int   r;
        int   ph;
        o = '{3'd0, 8'hFF, 8'h00, 1'b0};
        if (run) begin
            r    = (t / P) % 8;
            ph   = t % P;
            o.r  = r[2:0];
            if (ph == 0) begin
                o.fd = (r == 0);
            end else if (ph <= SD) begin
                o.dr = 8'(~(8'b1 << r));
                o.dc = col;
            end
        end
        return o;
    endfunction

    always @(negedge clock) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{row_count, dot_row, dot_col, frame_done};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs @%0t got r=%0d row=%h col=%h fd=%b want r=%0d row=%h col=%h fd=%b",
                         $time, a.r, a.dr, a.dc, a.fd, e.r, e.dr, e.dc, e.fd);
            end
            checks++;
            if ($countones(~dot_row) > 1) begin
                errors++;
                $display("FAIL onehot @%0t got row=%h want at most one low bit",
                         $time, dot_row);
            end
        end
    end

    bit         run = 1'b0;
    int         t = 0;
    int         r;
    int         ph;
    logic [7:0] cur_col = 8'h00;
    bit         dropped = 1'b0;
    bit         rst_done = 1'b0;
    int         off_cnt = 0;

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        col_data = 8'h00;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            @(posedge clock);
            #1;
            if (reset || !enable) begin
                run = 1'b0;
                t   = 0;
            end else if (!run) begin
                run = 1'b1;
                t   = 0;
            end else begin
                t++;
            end
            r  = (t / P) % 8;
            ph = t % P;
            if (run && ph == 0)
                cur_col = (t < 8 * P) ? 8'(r) : 8'($urandom);
            exp_q.push_back(model(run, t, cur_col));
            col_data = (run && ph == 0) ? cur_col : 8'($urandom);

            reset  = 1'b0;
            enable = 1'b1;
            if (cyc < 1) begin
                reset = 1'b1;
            end else if (cyc < 2 + 24 * P + 5) begin
                enable = 1'b1;
            end else if (!dropped) begin
                if (run && r == 5 && ph == 2) begin
                    enable  = 1'b0;
                    dropped = 1'b1;
                    off_cnt = 3;
                end
            end else if (off_cnt > 0) begin
                enable = 1'b0;
                off_cnt--;
            end else if (!rst_done) begin
                if (run && r == 2 && ph == 3) begin
                    reset    = 1'b1;
                    rst_done = 1'b1;
                end
            end else begin
                enable = ($urandom_range(0, 30) != 0);
                reset  = ($urandom_range(0, 60) == 0);
            end
        end
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
